// File: rtl/cdiv_pkg.sv
// cdiv_pkg: shared types and helpers for the cdiv complex divider.
//   - cdiv_state_e : control FSM states
//   - default widths and width-derivation functions (numerator, denominator,
//     dividend, iteration count)
//   - sat_lim      : symmetric saturation limit of a signed quotient component
package cdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    NORM = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } cdiv_state_e;

  localparam int CDIV_AWIDTH = 16;
  localparam int CDIV_BWIDTH = 18;
  localparam int CDIV_QWIDTH = 18;
  localparam int CDIV_FRAC   = 15;

  // Signed numerator width: sum of two AWIDTH x BWIDTH products.
  function automatic int num_w(input int aw, input int bw);
    return aw + bw + 1;
  endfunction

  // Unsigned |b|^2 width.
  function automatic int den_w(input int bw);
    return 2 * bw;
  endfunction

  // Dividend magnitude |n|*2^FRAC, one spare bit for the rounding add.
  function automatic int dvd_w(input int aw, input int bw, input int frac);
    return aw + bw + 1 + frac + 1;
  endfunction

  // Quotient magnitude bits produced by the divider (one per DIV cycle).
  function automatic int iters(input int qw);
    return qw - 1;
  endfunction

  // +/-(2^(qw-1)-1), returned in a 64-bit container; caller truncates.
  function automatic logic [63:0] sat_lim(input int qw, input logic neg);
    logic [63:0] lim;
    lim = (64'd1 << (qw - 1)) - 64'd1;
    if (neg) begin
      return ~lim + 64'd1;
    end else begin
      return lim;
    end
  endfunction

endpackage

// File: rtl/cdiv_udiv.sv
// cdiv_udiv: unsigned iterative restoring divider, one quotient bit per step,
// MSB first. The caller guarantees dividend < divisor*2^MW so the quotient
// fits MW bits.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture dividend/divisor and clear the quotient
//   step            : perform one restoring iteration
//   dividend        : XW-bit unsigned dividend
//   divisor         : DW-bit unsigned divisor
//   mag             : quotient including the bit decided in the current cycle,
//                     so on the last step it is already the final magnitude
module cdiv_udiv #(
  parameter int XW = 51,
  parameter int DW = 36,
  parameter int MW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [MW-1:0] mag
);

  localparam int SW = DW + MW;
  localparam int CW = (XW > SW) ? XW : SW;

  logic [XW-1:0] rem_r;
  logic [SW-1:0] dsh_r;   // divisor aligned to the current quotient bit
  logic [MW-2:0] q_r;
  logic          ge_s;

  // Trial compare of the partial remainder against the aligned divisor.
  always_comb begin
    ge_s = (CW'(rem_r) >= CW'(dsh_r));
    mag  = {q_r, ge_s};
  end

  // Remainder, aligned divisor and quotient shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r <= {XW{1'b0}};
      dsh_r <= {SW{1'b0}};
      q_r   <= {(MW-1){1'b0}};
    end else if (load) begin
      rem_r <= dividend;
      dsh_r <= SW'(divisor) << (MW - 1);
      q_r   <= {(MW-1){1'b0}};
    end else if (step) begin
      // When ge_s holds, dsh_r <= rem_r, so truncation to XW is exact.
      if (ge_s) begin
        rem_r <= rem_r - XW'(dsh_r);
      end
      dsh_r <= dsh_r >> 1;
      q_r   <= mag[MW-2:0];
    end
  end

endmodule

// File: rtl/cdiv.sv
// cdiv: sequential fixed-point complex divider q = a*conj(b)/|b|^2 * 2^FRAC.
// One division in flight; valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   ar, ai / br, bi     : signed dividend / divisor components
//   out_valid, out_ready: result handshake
//   qr, qi              : signed quotient components (registered)
//   ovf                 : a component saturated
//   dbz                 : divisor was 0+0j (quotient forced to 0)
// Build option: define CDIV_ROUND_EN to round half away from zero instead of
// truncating toward zero (adds den>>1 to each dividend magnitude).
module cdiv
  import cdiv_pkg::*;
#(
  parameter int AWIDTH = CDIV_AWIDTH,
  parameter int BWIDTH = CDIV_BWIDTH,
  parameter int QWIDTH = CDIV_QWIDTH,
  parameter int FRAC   = CDIV_FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [AWIDTH-1:0] ar,
  input  logic signed [AWIDTH-1:0] ai,
  input  logic signed [BWIDTH-1:0] br,
  input  logic signed [BWIDTH-1:0] bi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [QWIDTH-1:0] qr,
  output logic signed [QWIDTH-1:0] qi,
  output logic                     ovf,
  output logic                     dbz
);

  localparam int NW = num_w(AWIDTH, BWIDTH);
  localparam int DW = den_w(BWIDTH);
  localparam int XW = dvd_w(AWIDTH, BWIDTH, FRAC);
  localparam int MW = iters(QWIDTH);
  localparam int CW = (XW > DW + MW) ? XW : DW + MW;
  localparam int KW = (MW > 1) ? $clog2(MW) : 1;

  cdiv_state_e              state_r;
  logic signed [AWIDTH-1:0] ar_r, ai_r;
  logic signed [BWIDTH-1:0] br_r, bi_r;
  logic signed [NW-1:0]     nr_r, ni_r, nr_s, ni_s;
  logic [DW-1:0]            den_r, den_s;
  logic                     sgn_re_r, sgn_im_r, ovf_re_r, ovf_im_r, dbz_r;
  logic [KW-1:0]            cnt_r;
  logic                     out_valid_r, ovf_out_r, dbz_out_r;
  logic signed [QWIDTH-1:0] qr_r, qi_r, res_re_s, res_im_s;
  logic [NW-1:0]            abs_re_s, abs_im_s;
  logic [XW-1:0]            x_re_s, x_im_s;
  logic [CW-1:0]            lim_s;
  logic                     ovf_re_s, ovf_im_s;
  logic [MW-1:0]            mag_re_s, mag_im_s;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign qr        = qr_r;
  assign qi        = qi_r;
  assign ovf       = ovf_out_r;
  assign dbz       = dbz_out_r;

  // Complex numerator a*conj(b) and denominator |b|^2 from captured operands.
  always_comb begin
    nr_s  = NW'(ar_r) * NW'(br_r) + NW'(ai_r) * NW'(bi_r);
    ni_s  = NW'(ai_r) * NW'(br_r) - NW'(ar_r) * NW'(bi_r);
    den_s = DW'(DW'(br_r) * DW'(br_r) + DW'(bi_r) * DW'(bi_r));
  end

  // Scaled dividend magnitudes and overflow test against den*2^MW.
  always_comb begin
    abs_re_s = nr_r[NW-1] ? $unsigned(-nr_r) : $unsigned(nr_r);
    abs_im_s = ni_r[NW-1] ? $unsigned(-ni_r) : $unsigned(ni_r);
    x_re_s   = XW'(abs_re_s) << FRAC;
    x_im_s   = XW'(abs_im_s) << FRAC;
`ifdef CDIV_ROUND_EN
    x_re_s   = x_re_s + XW'(den_r >> 1);
    x_im_s   = x_im_s + XW'(den_r >> 1);
`endif
    lim_s    = CW'(den_r) << MW;
    ovf_re_s = (CW'(x_re_s) >= lim_s);
    ovf_im_s = (CW'(x_im_s) >= lim_s);
  end

  // Final signed, saturated, zero-on-dbz result of each component.
  always_comb begin
    if (dbz_r) begin
      res_re_s = {QWIDTH{1'b0}};
    end else if (ovf_re_r) begin
      res_re_s = QWIDTH'(sat_lim(QWIDTH, sgn_re_r));
    end else if (sgn_re_r) begin
      res_re_s = -QWIDTH'(mag_re_s);
    end else begin
      res_re_s = QWIDTH'(mag_re_s);
    end
    if (dbz_r) begin
      res_im_s = {QWIDTH{1'b0}};
    end else if (ovf_im_r) begin
      res_im_s = QWIDTH'(sat_lim(QWIDTH, sgn_im_r));
    end else if (sgn_im_r) begin
      res_im_s = -QWIDTH'(mag_im_s);
    end else begin
      res_im_s = QWIDTH'(mag_im_s);
    end
  end

  cdiv_udiv #(.XW(XW), .DW(DW), .MW(MW)) u_div_re (
    .clk      (clk),
    .rst      (rst),
    .load     (state_r == NORM),
    .step     (state_r == DIV),
    .dividend (x_re_s),
    .divisor  (den_r),
    .mag      (mag_re_s)
  );

  cdiv_udiv #(.XW(XW), .DW(DW), .MW(MW)) u_div_im (
    .clk      (clk),
    .rst      (rst),
    .load     (state_r == NORM),
    .step     (state_r == DIV),
    .dividend (x_im_s),
    .divisor  (den_r),
    .mag      (mag_im_s)
  );

  // Control FSM with operand capture, NORM flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ar_r        <= {AWIDTH{1'b0}};
      ai_r        <= {AWIDTH{1'b0}};
      br_r        <= {BWIDTH{1'b0}};
      bi_r        <= {BWIDTH{1'b0}};
      nr_r        <= {NW{1'b0}};
      ni_r        <= {NW{1'b0}};
      den_r       <= {DW{1'b0}};
      sgn_re_r    <= 1'b0;
      sgn_im_r    <= 1'b0;
      ovf_re_r    <= 1'b0;
      ovf_im_r    <= 1'b0;
      dbz_r       <= 1'b0;
      cnt_r       <= {KW{1'b0}};
      out_valid_r <= 1'b0;
      qr_r        <= {QWIDTH{1'b0}};
      qi_r        <= {QWIDTH{1'b0}};
      ovf_out_r   <= 1'b0;
      dbz_out_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            ar_r    <= ar;
            ai_r    <= ai;
            br_r    <= br;
            bi_r    <= bi;
            state_r <= MULT;
          end
        end
        MULT: begin
          nr_r    <= nr_s;
          ni_r    <= ni_s;
          den_r   <= den_s;
          state_r <= NORM;
        end
        NORM: begin
          // Overflow is meaningless for a zero divisor; dbz alone reports it.
          sgn_re_r <= nr_r[NW-1];
          sgn_im_r <= ni_r[NW-1];
          dbz_r    <= (den_r == {DW{1'b0}});
          ovf_re_r <= ovf_re_s && (den_r != {DW{1'b0}});
          ovf_im_r <= ovf_im_s && (den_r != {DW{1'b0}});
          cnt_r    <= {KW{1'b0}};
          state_r  <= DIV;
        end
        DIV: begin
          if (cnt_r == KW'(MW - 1)) begin
            qr_r        <= res_re_s;
            qi_r        <= res_im_s;
            ovf_out_r   <= ovf_re_r | ovf_im_r;
            dbz_out_r   <= dbz_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdiv.sv
// tb_cdiv: self-checking bench for cdiv (directed table, corner sequences,
// randomized operations against an arithmetic reference model).
module tb_cdiv;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] ar, ai;
  logic signed [17:0] br, bi;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] qr, qi;
  logic               ovf, dbz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cdiv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .qr        (qr),
    .qi        (qi),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  typedef struct {
    string  nm;
    longint ar, ai, br, bi;
    longint eqr, eqi;
    bit     eovf, edbz;
    int     hold;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: q = a*conj(b)/|b|^2 * 2^15, truncated (or rounded half away
  // from zero), saturated symmetrically to +/-(2^17-1).
  function automatic void model(input longint a_r, a_i, b_r, b_i,
                                output longint q_r, q_i,
                                output bit o, z);
    longint n[2];
    longint q[2];
    longint den, x, lim;
    n[0] = a_r * b_r + a_i * b_i;
    n[1] = a_i * b_r - a_r * b_i;
    den  = b_r * b_r + b_i * b_i;
    lim  = 131071;
    o = 1'b0;
    z = (den == 0);
    for (int k = 0; k < 2; k++) begin
      if (z) begin
        q[k] = 0;
      end else begin
        x = (n[k] < 0 ? -n[k] : n[k]) * 32768;
`ifdef CDIV_ROUND_EN
        x = x + den / 2;
`endif
        if (x / den > lim) begin
          o = 1'b1;
          q[k] = lim;
        end else begin
          q[k] = x / den;
        end
        if (n[k] < 0) q[k] = -q[k];
      end
    end
    q_r = q[0];
    q_i = q[1];
  endfunction

  // One full transaction; checks latency, results, optional stall stability.
  task automatic run_op(input string nm, input longint a_r, a_i, b_r, b_i,
                        input longint eqr, eqi, input bit eovf, edbz,
                        input int hold);
    int wt;
    int lat;
    longint sq_r, sq_i;
    wt = 0;
    while (!in_ready && wt < 100) begin
      @(posedge clk); #1; wt++;
    end
    if (!in_ready) begin
      chk({nm, "_inready_timeout"}, 0, 1);
      return;
    end
    ar = 16'(a_r); ai = 16'(a_i); br = 18'(b_r); bi = 18'(b_i);
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Junk on the inputs while busy must be ignored.
    ar = 16'($urandom); ai = 16'($urandom);
    br = 18'($urandom); bi = 18'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, lat, 19);
    chk({nm, "_qr"}, longint'(qr), eqr);
    chk({nm, "_qi"}, longint'(qi), eqi);
    chk({nm, "_ovf"}, ovf, eovf);
    chk({nm, "_dbz"}, dbz, edbz);
    sq_r = longint'(qr);
    sq_i = longint'(qi);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk({nm, "_stall_valid"}, out_valid, 1);
      chk({nm, "_stall_inready"}, in_ready, 0);
      chk({nm, "_stall_qr"}, longint'(qr), sq_r);
      chk({nm, "_stall_qi"}, longint'(qi), sq_i);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_post_valid"}, out_valid, 0);
    chk({nm, "_post_inready"}, in_ready, 1);
  endtask

  vec_t   vecs[6];
  longint mr, mi;
  bit     mo, mz;
  longint ra_r, ra_i, rb_r, rb_i;
  int     wt;

  initial begin
    vecs[0] = '{"unity",   100, 0, 100, 0,  32768, 0, 1'b0, 1'b0, 5};
    vecs[1] = '{"rot_j",   1, 1, 1, -1,     0, 32768, 1'b0, 1'b0, 0};
    vecs[2] = '{"neg",     -3, 0, 2, 0,     -49152, 0, 1'b0, 1'b0, 0};
`ifdef CDIV_ROUND_EN
    vecs[3] = '{"third",   1, 0, 3, 0,      10923, 0, 1'b0, 1'b0, 0};
`else
    vecs[3] = '{"third",   1, 0, 3, 0,      10922, 0, 1'b0, 1'b0, 0};
`endif
    vecs[4] = '{"sat",     32767, 0, 1, 0,  131071, 0, 1'b1, 1'b0, 0};
    vecs[5] = '{"dbz",     5, 5, 0, 0,      0, 0, 1'b0, 1'b1, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ar = 16'sd0; ai = 16'sd0; br = 18'sd0; bi = 18'sd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_qr", longint'(qr), 0);
    chk("rst_qi", longint'(qi), 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    rst = 1'b0;
    #1;
    chk("rel_inready", in_ready, 1);

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].nm, vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi,
             vecs[v].eqr, vecs[v].eqi, vecs[v].eovf, vecs[v].edbz,
             vecs[v].hold);
    end

    // Reset pulse in the middle of DIV aborts the operation.
    ar = 16'sd1000; ai = 16'sd0; br = 18'sd3; bi = 18'sd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_inready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_qr", longint'(qr), 0);
    chk("abort_qi", longint'(qi), 0);
    chk("abort_inready", in_ready, 1);
    wt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) wt++;
    end
    chk("abort_no_result", wt, 0);

    // Randomized operations against the reference model.
    for (int r = 0; r < 60; r++) begin
      ra_r = longint'($signed(16'($urandom)));
      ra_i = longint'($signed(16'($urandom)));
      rb_r = longint'($signed(18'($urandom)));
      rb_i = longint'($signed(18'($urandom)));
      case ($urandom_range(0, 3))
        0: begin
          rb_r = longint'($urandom_range(0, 16)) - 8;
          rb_i = longint'($urandom_range(0, 16)) - 8;
        end
        1: begin
          rb_r = rb_r / 256;
          rb_i = rb_i / 256;
        end
        2: begin
          ra_r = ra_r / 64;
          if ($urandom_range(0, 3) == 0) begin
            rb_r = 0;
            rb_i = 0;
          end
        end
        default: begin
        end
      endcase
      model(ra_r, ra_i, rb_r, rb_i, mr, mi, mo, mz);
      run_op($sformatf("rnd%0d", r), ra_r, ra_i, rb_r, rb_i, mr, mi, mo, mz,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
